// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation sequencer and its core.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_SUB    = 2'd0,
        OP_LT     = 2'd1,
        OP_CLRBIT = 2'd2,
        OP_ZM2U2  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int ST_ZERR = 0;
    localparam int ST_NEG  = 1;
    localparam int ST_PAR  = 2;
    localparam int ST_ONES = 3;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command/result handshake bundle between a command source and the sequencer.
interface alu_op_sequencer_if #(
    parameter int m = 4,
    parameter int n = 2
);
    logic         i_valid;
    logic         o_ready;
    logic [n-1:0] i_op;
    logic [m-1:0] i_argA;
    logic [m-1:0] i_argB;
    logic         o_valid;
    logic         i_ready;
    logic [m-1:0] o_result;
    logic [3:0]   o_status;

    modport slave (
        input  i_valid, i_op, i_argA, i_argB, i_ready,
        output o_ready, o_valid, o_result, o_status
    );

    modport master (
        output i_valid, i_op, i_argA, i_argB, i_ready,
        input  o_ready, o_valid, o_result, o_status
    );
endinterface

// File: rtl/alu_op_core.sv
// Combinational evaluation of one ALU command: result, status flags, error flag.
module alu_op_core
    import alu_pkg::*;
#(
    parameter int m = 4,
    parameter int n = 2
) (
    input  logic [n-1:0] op,
    input  logic [m-1:0] a,
    input  logic [m-1:0] b,
    output logic [m-1:0] result,
    output logic [3:0]   status,
    output logic         err
);
    logic [m-1:0] bit_sel;
    logic         idx_ok;
    logic [m-2:0] mag_a;
    logic [m-2:0] mag_b;
    logic         lt;
    logic         idx_err;
    logic         bad_op;
    logic         is_zm2u2;

    // One-hot of the bit index; all-zero when the index is out of range,
    // which also covers B[m-1]=1 since m-1 < 2^(m-1).
    for (genvar gi = 0; gi < m; gi++) begin : g_sel
        assign bit_sel[gi] = (b == m'(gi));
    end
    assign idx_ok = |bit_sel;

    assign mag_a = a[m-2:0];
    assign mag_b = b[m-2:0];
    assign lt = ((mag_a == '0) && (mag_b == '0)) ? 1'b0 :
                (a[m-1] != b[m-1])               ? a[m-1] :
                a[m-1]                           ? (mag_a > mag_b) :
                                                   (mag_a < mag_b);

    always_comb begin
        result   = '0;
        idx_err  = 1'b0;
        bad_op   = 1'b0;
        is_zm2u2 = 1'b0;
        case (op)
            n'(OP_SUB):    result = a - b;
            n'(OP_LT):     result = {{(m-1){1'b0}}, lt};
            n'(OP_CLRBIT): begin
                result  = a & ~bit_sel;
                idx_err = ~idx_ok;
            end
            n'(OP_ZM2U2):  begin
                result   = a[m-1] ? (m'(0) - {1'b0, mag_a}) : a;
                is_zm2u2 = 1'b1;
            end
            default:       bad_op = 1'b1;
        endcase
    end

    always_comb begin
        status          = '0;
        status[ST_ZERR] = (result == '0) | idx_err | bad_op;
        status[ST_NEG]  = result[m-1];
        status[ST_PAR]  = ~^result;
        status[ST_ONES] = &result;
    end

    assign err = idx_err | bad_op | (is_zm2u2 & (result == '0));

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts one ALU command, evaluates it, holds the result until consumed, and counts completions.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int m     = 4,
    parameter int n     = 2,
    parameter int CNT_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    alu_op_sequencer_if.slave   bus,
    output logic [CNT_W-1:0]    o_op_cnt,
    output logic [CNT_W-1:0]    o_err_cnt
);
    state_e           state_reg;
    state_e           state_next;
    logic             capture;
    logic [n-1:0]     op_reg;
    logic [m-1:0]     a_reg;
    logic [m-1:0]     b_reg;
    logic [m-1:0]     result_reg;
    logic [3:0]       status_reg;
    logic [CNT_W-1:0] op_cnt_reg;
    logic [CNT_W-1:0] err_cnt_reg;
    logic [m-1:0]     core_result;
    logic [3:0]       core_status;
    logic             core_err;

    alu_op_core #(.m(m), .n(n)) u_core (
        .op     (op_reg),
        .a      (a_reg),
        .b      (b_reg),
        .result (core_result),
        .status (core_status),
        .err    (core_err)
    );

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            S_IDLE: if (bus.i_valid) begin
                capture    = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: state_next = S_DONE;
            S_DONE: if (bus.i_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= S_IDLE;
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            result_reg  <= '0;
            status_reg  <= '0;
            op_cnt_reg  <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                op_reg <= bus.i_op;
                a_reg  <= bus.i_argA;
                b_reg  <= bus.i_argB;
            end
            if (state_reg == S_EXEC) begin
                result_reg <= core_result;
                status_reg <= core_status;
                // Counters stick at all-ones instead of wrapping.
                if (op_cnt_reg != '1)
                    op_cnt_reg <= op_cnt_reg + CNT_W'(1);
                if (core_err && (err_cnt_reg != '1))
                    err_cnt_reg <= err_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.o_ready  = (state_reg == S_IDLE);
    assign bus.o_valid  = (state_reg == S_DONE);
    assign bus.o_result = result_reg;
    assign bus.o_status = status_reg;
    assign o_op_cnt     = op_cnt_reg;
    assign o_err_cnt    = err_cnt_reg;

endmodule
